// File: rtl/edge_count_readout.sv
// edge_count_readout: FWFT readout FIFO for 128-bit edge-count words with overflow and drop tracking.
module edge_count_readout #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write,
  input  logic [127:0]          count_in,
  input  logic                  clear,
  output logic [127:0]          m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  fifo_empty,
  output logic                  fifo_full,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  overflow,
  output logic [15:0]           drop_count
);
  localparam int LW = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] FULL_LEVEL = LW'(FIFO_DEPTH);
  logic [127:0] mem [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [127:0] word;
  logic push, pop, drop;
  logic unused_bits;
  assign unused_bits = ^count_in[63:DATA_WIDTH];
  assign word = {count_in[127:64], {(64-DATA_WIDTH){1'b0}}, count_in[DATA_WIDTH-1:0]};
  assign fifo_empty = level == '0;
  assign fifo_full = level == FULL_LEVEL;
  assign m_valid = ~fifo_empty;
  assign m_data = mem[rd_ptr];
  assign pop = m_valid & m_ready & ~clear;
  assign push = write & ~clear & (~fifo_full | pop);
  assign drop = write & ~clear & fifo_full & ~pop;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= word;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      overflow <= 1'b0;
      drop_count <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      overflow <= 1'b0;
      drop_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (pop) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      level <= level + LW'(push) - LW'(pop);
      if (drop) overflow <= 1'b1;
      if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
    end
endmodule

// File: tb/tb_edge_count_readout.sv
// tb_edge_count_readout: directed self-checking bench for edge_count_readout.
module tb_edge_count_readout;
  logic clk = 1'b0;
  logic reset, write, clear, m_ready;
  logic [127:0] count_in, m_data;
  logic m_valid, fifo_empty, fifo_full, overflow;
  logic [4:0] level;
  logic [15:0] drop_count;
  int checks = 0;
  int failures = 0;
  edge_count_readout #(.DATA_WIDTH(16), .FIFO_DEPTH(16), .ADDR_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .write(write), .count_in(count_in), .clear(clear),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .fifo_empty(fifo_empty),
    .fifo_full(fifo_full), .level(level), .overflow(overflow), .drop_count(drop_count)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [127:0] mk(input logic [63:0] ts, input logic [15:0] cnt);
    return {ts, 48'h0, cnt};
  endfunction
  task automatic push_word(input logic [63:0] ts, input logic [63:0] lo);
    write = 1'b1;
    count_in = {ts, lo};
    step();
    write = 1'b0;
  endtask
  initial begin
    logic [6:0] pat;
    int idx;
    reset = 1'b0; write = 1'b0; clear = 1'b0; m_ready = 1'b0; count_in = '0;
    #3;
    check("rst_valid", 128'(m_valid), 128'(0));
    check("rst_empty", 128'(fifo_empty), 128'(1));
    check("rst_full", 128'(fifo_full), 128'(0));
    check("rst_level", 128'(level), 128'(0));
    check("rst_ovf", 128'(overflow), 128'(0));
    check("rst_drop", 128'(drop_count), 128'(0));
    step(); step();
    reset = 1'b1;
    // single capture: upper count bits are masked to zero
    push_word(64'h1234, 64'hFFFF_FFFF_FFFF_00AB);
    check("single_valid", 128'(m_valid), 128'(1));
    check("single_data", m_data, {64'h1234, 64'h00AB});
    check("single_level", 128'(level), 128'(1));
    step();
    check("single_hold", m_data, {64'h1234, 64'h00AB});
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    check("single_popped", 128'(m_valid), 128'(0));
    check("single_empty", 128'(fifo_empty), 128'(1));
    // fill past capacity
    for (int i = 0; i < 18; i++) begin
      push_word(64'h100, 64'(i));
      if (i == 15) check("fill_full16", 128'(fifo_full), 128'(1));
    end
    check("fill_level", 128'(level), 128'(16));
    check("fill_ovf", 128'(overflow), 128'(1));
    check("fill_drop", 128'(drop_count), 128'(2));
    m_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("drain_%0d", i), m_data, mk(64'h100, 16'(i)));
      step();
    end
    m_ready = 1'b0;
    check("drain_empty", 128'(fifo_empty), 128'(1));
    // full with simultaneous pop
    for (int i = 0; i < 16; i++) push_word(64'h200, 64'(32 + i));
    check("refill_full", 128'(fifo_full), 128'(1));
    write = 1'b1; m_ready = 1'b1; count_in = {64'h200, 64'd99};
    step();
    write = 1'b0; m_ready = 1'b0;
    check("fullpop_level", 128'(level), 128'(16));
    check("fullpop_drop", 128'(drop_count), 128'(2));
    check("fullpop_head", m_data, mk(64'h200, 16'd33));
    m_ready = 1'b1;
    for (int i = 1; i < 16; i++) begin
      check($sformatf("fp_drain_%0d", i), m_data, mk(64'h200, 16'(32 + i)));
      step();
    end
    check("fullpop_last", m_data, mk(64'h200, 16'd99));
    step();
    m_ready = 1'b0;
    check("fullpop_empty", 128'(fifo_empty), 128'(1));
    // backpressure: head must hold while m_ready is low
    for (int i = 0; i < 3; i++) push_word(64'h300, 64'(200 + i));
    pat = 7'b1010010;
    idx = 0;
    for (int k = 0; k < 7; k++) begin
      m_ready = pat[k];
      check($sformatf("bp_valid_%0d", k), 128'(m_valid), 128'(1));
      check($sformatf("bp_data_%0d", k), m_data, mk(64'h300, 16'(200 + idx)));
      step();
      if (pat[k]) idx++;
      if (idx == 3) break;
    end
    m_ready = 1'b0;
    check("bp_empty", 128'(fifo_empty), 128'(1));
    // clear beats a same-cycle write
    for (int i = 0; i < 5; i++) push_word(64'h400, 64'(i));
    check("clr_pre_ovf", 128'(overflow), 128'(1));
    clear = 1'b1; write = 1'b1; count_in = {64'h400, 64'd777};
    step();
    clear = 1'b0; write = 1'b0;
    check("clr_level", 128'(level), 128'(0));
    check("clr_empty", 128'(fifo_empty), 128'(1));
    check("clr_ovf", 128'(overflow), 128'(0));
    check("clr_drop", 128'(drop_count), 128'(0));
    step();
    check("clr_nostore", 128'(level), 128'(0));
    // asynchronous reset mid-operation
    for (int i = 0; i < 8; i++) push_word(64'h500, 64'(i));
    check("mid_level", 128'(level), 128'(8));
    #2 reset = 1'b0;
    #1;
    check("async_valid", 128'(m_valid), 128'(0));
    check("async_level", 128'(level), 128'(0));
    check("async_empty", 128'(fifo_empty), 128'(1));
    #2 reset = 1'b1;
    push_word(64'h600, 64'h555);
    check("post_level", 128'(level), 128'(1));
    check("post_data", m_data, mk(64'h600, 16'h555));
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    check("post_empty", 128'(fifo_empty), 128'(1));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
